// File: rtl/wb_arb_pkg.sv
// Shared types and width helpers for the Wishbone round-robin arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWNED   = 2'd1,
    TIMEOUT = 2'd2
  } arb_state_e;

  // Index/counter width that never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Rotate-priority picker: first requester at index >= ptr, wrapping modulo N.
module wb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          valid
);

  int unsigned     cand;
  logic [IW-1:0]   cand_idx;

  // Scan from ptr upward; the first hit wins and later hits are ignored.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    valid      = 1'b0;
    cand       = 0;
    cand_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= N) cand = cand - N;
      cand_idx = IW'(cand);
      if (!valid && req[cand_idx]) begin
        valid               = 1'b1;
        gnt_idx             = cand_idx;
        gnt_onehot[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS masters share one slave bus,
// grants last a whole cyc period, and a watchdog errors out hung slaves.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                            wb_clk_i,
  input  logic                            rst_i,
  input  logic [NUM_MASTERS-1:0]          m_cyc_i,
  input  logic [NUM_MASTERS-1:0]          m_stb_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr_i,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata_i,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_sel_i,
  output logic [NUM_MASTERS-1:0]          m_ack_o,
  output logic [NUM_MASTERS-1:0]          m_err_o,
  output logic [DATA_W-1:0]               m_rdata_o,
  output logic                            s_cyc_o,
  output logic                            s_stb_o,
  output logic                            s_we_o,
  output logic [ADDR_W-1:0]               s_addr_o,
  output logic [DATA_W-1:0]               s_wdata_o,
  output logic [DATA_W/8-1:0]             s_sel_o,
  input  logic [DATA_W-1:0]               s_rdata_i,
  input  logic                            s_ack_i,
  output logic [NUM_MASTERS-1:0]          grant_o
);

  localparam int unsigned IDX_W = idx_w(NUM_MASTERS);
  localparam int unsigned SEL_W = DATA_W / 8;
  localparam int unsigned TMR_W = idx_w(TIMEOUT_CYCLES + 1);
  localparam bit          WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = '1;

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [TMR_W-1:0]       timer_q, timer_d;

  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;

  logic [ADDR_W-1:0]      addr_arr  [NUM_MASTERS];
  logic [DATA_W-1:0]      wdata_arr [NUM_MASTERS];
  logic [SEL_W-1:0]       sel_arr   [NUM_MASTERS];

  logic                   own_cyc, own_stb, own_we;
  logic [IDX_W-1:0]       rr_after;

  // Unpack the per-master buses so the owner can be selected by index.
  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
    assign addr_arr[gi]  = m_addr_i[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = m_wdata_i[gi*DATA_W +: DATA_W];
    assign sel_arr[gi]   = m_sel_i[gi*SEL_W +: SEL_W];
  end

  wb_rr_pick #(
    .N  (NUM_MASTERS),
    .IW (IDX_W)
  ) u_pick (
    .req        (m_cyc_i),
    .ptr        (rr_ptr_q),
    .gnt_onehot (pick_onehot),
    .gnt_idx    (pick_idx),
    .valid      (pick_valid)
  );

  // A strobe without cyc is not a transfer.
  assign own_cyc  = m_cyc_i[owner_q];
  assign own_stb  = m_stb_i[owner_q] & own_cyc;
  assign own_we   = m_we_i[owner_q];
  assign rr_after = (owner_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : owner_q + IDX_W'(1);

  assign m_rdata_o = s_rdata_i;
  assign grant_o   = grant_q;

  // Next-state, watchdog and bus routing; slave ack is only forwarded while owned.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    timer_d   = '0;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    s_sel_o   = '0;
    m_ack_o   = '0;
    m_err_o   = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = OWNED;
          grant_d = pick_onehot;
          owner_d = pick_idx;
        end
      end

      OWNED: begin
        s_cyc_o   = own_cyc;
        s_stb_o   = own_stb;
        s_we_o    = own_we;
        s_addr_o  = addr_arr[owner_q];
        s_wdata_o = wdata_arr[owner_q];
        s_sel_o   = sel_arr[owner_q];
        m_ack_o   = rst_i ? '0 : (grant_q & {NUM_MASTERS{s_ack_i}});

        if (!own_cyc) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = rr_after;
        end else if (own_stb && !s_ack_i) begin
          if (WD_EN && (timer_q == TMR_LAST)) begin
            state_d = TIMEOUT;
          end else begin
            timer_d = (timer_q == TMR_MAX) ? timer_q : timer_q + TMR_W'(1);
          end
        end else if (!s_ack_i) begin
          timer_d = timer_q;
        end
      end

      TIMEOUT: begin
        m_err_o  = rst_i ? '0 : grant_q;
        state_d  = IDLE;
        grant_d  = '0;
        rr_ptr_d = rr_after;
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State, grant, round-robin pointer and watchdog registers.
  always_ff @(posedge wb_clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      timer_q  <= timer_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: one instance with a short watchdog,
// one with the watchdog disabled, driven from shared master/slave stimulus.
module tb_wb_rr_arbiter;

  logic        wb_clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  m_cyc, m_stb, m_we;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_sel;
  logic [31:0] s_rdata;
  logic        s_ack;

  logic [1:0]  m_ack, m_err, grant;
  logic [31:0] m_rdata, s_addr, s_wdata;
  logic [3:0]  s_sel;
  logic        s_cyc, s_stb, s_we;

  logic [1:0]  nt_m_ack, nt_m_err, nt_grant;
  logic [31:0] nt_m_rdata, nt_s_addr, nt_s_wdata;
  logic [3:0]  nt_s_sel;
  logic        nt_s_cyc, nt_s_stb, nt_s_we;

  int n_tests;
  int n_fail;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_rr_arbiter #(
    .NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)
  ) u_dut (
    .wb_clk_i (wb_clk_i), .rst_i (rst_i),
    .m_cyc_i (m_cyc), .m_stb_i (m_stb), .m_we_i (m_we),
    .m_addr_i (m_addr), .m_wdata_i (m_wdata), .m_sel_i (m_sel),
    .m_ack_o (m_ack), .m_err_o (m_err), .m_rdata_o (m_rdata),
    .s_cyc_o (s_cyc), .s_stb_o (s_stb), .s_we_o (s_we),
    .s_addr_o (s_addr), .s_wdata_o (s_wdata), .s_sel_o (s_sel),
    .s_rdata_i (s_rdata), .s_ack_i (s_ack), .grant_o (grant)
  );

  wb_rr_arbiter #(
    .NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(0)
  ) u_dut_nt (
    .wb_clk_i (wb_clk_i), .rst_i (rst_i),
    .m_cyc_i (m_cyc), .m_stb_i (m_stb), .m_we_i (m_we),
    .m_addr_i (m_addr), .m_wdata_i (m_wdata), .m_sel_i (m_sel),
    .m_ack_o (nt_m_ack), .m_err_o (nt_m_err), .m_rdata_o (nt_m_rdata),
    .s_cyc_o (nt_s_cyc), .s_stb_o (nt_s_stb), .s_we_o (nt_s_we),
    .s_addr_o (nt_s_addr), .s_wdata_o (nt_s_wdata), .s_sel_o (nt_s_sel),
    .s_rdata_i (s_rdata), .s_ack_i (s_ack), .grant_o (nt_grant)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge wb_clk_i);
    #2;
  endtask

  task automatic drive_m(input int i, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel);
    m_cyc[i]            = cyc;
    m_stb[i]            = stb;
    m_we[i]             = we;
    m_addr[i*32 +: 32]  = a;
    m_wdata[i*32 +: 32] = d;
    m_sel[i*4 +: 4]     = sel;
  endtask

  task automatic do_reset();
    m_cyc = '0; m_stb = '0; m_we = '0; m_addr = '0; m_wdata = '0; m_sel = '0;
    s_rdata = '0; s_ack = 1'b0;
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  // Owner i gets one acked beat, then drops cyc; ends in the following IDLE cycle.
  task automatic release_owner(input int i, input string tag);
    logic [1:0] oh;
    oh = 2'b01 << i;
    s_ack = 1'b1;
    #1;
    check_eq({tag, "_ack"}, 64'(m_ack), 64'(oh));
    tick();
    s_ack = 1'b0;
    drive_m(i, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
  endtask

  initial begin
    int bad;
    n_tests = 0;
    n_fail  = 0;

    // Reset state
    do_reset();
    #1;
    check_eq("rst_grant", 64'(grant), 64'h0);
    check_eq("rst_scyc", 64'(s_cyc), 64'h0);
    check_eq("rst_ack_err", 64'({m_ack, m_err}), 64'h0);
    check_eq("rst_saddr", 64'(s_addr), 64'h0);

    // 1: single master write, slave acks on the second owned cycle
    drive_m(0, 1'b1, 1'b1, 1'b1, 32'hF000_0004, 32'hA5A5_5A5A, 4'hF);
    #1;
    check_eq("t1_idle_scyc", 64'(s_cyc), 64'h0);
    tick();
    check_eq("t1_grant", 64'(grant), 64'h1);
    check_eq("t1_scyc", 64'({s_cyc, s_stb, s_we}), 64'h7);
    check_eq("t1_saddr", 64'(s_addr), 64'hF000_0004);
    check_eq("t1_swdata", 64'(s_wdata), 64'hA5A5_5A5A);
    check_eq("t1_ssel", 64'(s_sel), 64'hF);
    check_eq("t1_noack", 64'(m_ack), 64'h0);
    tick();
    s_ack = 1'b1;
    #1;
    check_eq("t1_ack", 64'(m_ack), 64'h1);
    tick();
    s_ack = 1'b0;
    drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    check_eq("t1_ack_once", 64'(m_ack), 64'h0);
    check_eq("t1_grant_hold", 64'(grant), 64'h1);
    tick();
    check_eq("t1_grant_clr", 64'(grant), 64'h0);

    // 2: contention after reset -> m0 then m1; then with rr_ptr=1 -> m1 first
    do_reset();
    s_rdata = 32'hDEAD_BEEF;
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h11, 4'hF);
    drive_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h22, 4'hF);
    tick();
    check_eq("t2_first_m0", 64'(grant), 64'h1);
    check_eq("t2_saddr_m0", 64'(s_addr), 64'h100);
    check_eq("t2_rdata", 64'(m_rdata), 64'hDEAD_BEEF);
    release_owner(0, "t2_m0");
    check_eq("t2_idle_gap", 64'(grant), 64'h0);
    tick();
    check_eq("t2_then_m1", 64'(grant), 64'h2);
    check_eq("t2_saddr_m1", 64'(s_addr), 64'h200);
    release_owner(1, "t2_m1");
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'hF);
    tick();
    check_eq("t2_solo_m0", 64'(grant), 64'h1);
    release_owner(0, "t2_solo");
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0108, 32'h0, 4'hF);
    drive_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0208, 32'h0, 4'hF);
    tick();
    check_eq("t2_repeat_m1", 64'(grant), 64'h2);

    // 3: m1 burst of three beats while m0 waits
    do_reset();
    drive_m(1, 1'b1, 1'b1, 1'b1, 32'h0000_0300, 32'h30, 4'hF);
    tick();
    check_eq("t3_grant_m1", 64'(grant), 64'h2);
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h40, 4'h3);
    for (int k = 0; k < 3; k++) begin
      m_addr[32 +: 32] = 32'h0000_0300 + 32'(4 * k);
      s_ack = 1'b1;
      #1;
      check_eq("t3_beat_addr", 64'(s_addr), 64'(32'h0000_0300 + 32'(4 * k)));
      check_eq("t3_beat_grant", 64'(grant), 64'h2);
      check_eq("t3_beat_ack", 64'(m_ack), 64'h2);
      tick();
    end
    s_ack = 1'b0;
    drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    check_eq("t3_m1_release", 64'(grant), 64'h2);
    tick();
    check_eq("t3_idle", 64'(grant), 64'h0);
    tick();
    check_eq("t3_m0_after", 64'(grant), 64'h1);
    check_eq("t3_m0_saddr", 64'(s_addr), 64'h400);
    check_eq("t3_m0_ssel", 64'(s_sel), 64'h3);
    release_owner(0, "t3_m0");

    // 4: watchdog fires after 4 unacked strobe cycles; ack on the 4th wins
    do_reset();
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 4'hF);
    tick();
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq("t4_stall", 64'({s_cyc, m_err}), 64'h4);
      tick();
    end
    s_ack = 1'b1;
    #1;
    check_eq("t4_err", 64'(m_err), 64'h1);
    check_eq("t4_scyc_low", 64'({s_cyc, s_stb}), 64'h0);
    check_eq("t4_no_ack", 64'(m_ack), 64'h0);
    check_eq("t4_grant_to", 64'(grant), 64'h1);
    tick();
    s_ack = 1'b0;
    #1;
    check_eq("t4_err_pulse", 64'(m_err), 64'h0);
    check_eq("t4_idle", 64'(grant), 64'h0);
    tick();
    check_eq("t4_regrant", 64'(grant), 64'h1);
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("t4b_stall", 64'({s_cyc, m_err}), 64'h4);
      tick();
    end
    s_ack = 1'b1;
    #1;
    check_eq("t4b_ack", 64'(m_ack), 64'h1);
    check_eq("t4b_no_err", 64'(m_err), 64'h0);
    tick();
    s_ack = 1'b0;
    drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    check_eq("t4b_no_err2", 64'(m_err), 64'h0);
    check_eq("t4b_owned", 64'(grant), 64'h1);
    tick();
    check_eq("t4b_idle", 64'({grant, m_err}), 64'h0);

    // 5: reset while owned with stb high (rr_ptr is 1 going in)
    drive_m(0, 1'b1, 1'b1, 1'b1, 32'h0000_0600, 32'h66, 4'hF);
    tick();
    check_eq("t5_grant", 64'(grant), 64'h1);
    rst_i = 1'b1;
    s_ack = 1'b1;
    #1;
    check_eq("t5_ack_in_rst", 64'(m_ack), 64'h0);
    tick();
    rst_i = 1'b0;
    s_ack = 1'b0;
    drive_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0700, 32'h0, 4'hF);
    #1;
    check_eq("t5_grant_clr", 64'(grant), 64'h0);
    check_eq("t5_s_ctl", 64'({s_cyc, s_stb, s_we}), 64'h0);
    check_eq("t5_s_addr", 64'(s_addr), 64'h0);
    check_eq("t5_ack_err", 64'({m_ack, m_err}), 64'h0);
    tick();
    check_eq("t5_rrptr0", 64'(grant), 64'h1);

    // 6: stray ack in IDLE; watchdog disabled with a 1000-cycle stall
    do_reset();
    s_ack = 1'b1;
    #1;
    check_eq("t6_stray_ack", 64'({m_ack, nt_m_ack}), 64'h0);
    tick();
    check_eq("t6_stray_grant", 64'({grant, nt_grant}), 64'h0);
    s_ack = 1'b0;
    drive_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0800, 32'h0, 4'hF);
    tick();
    check_eq("t6_nt_grant", 64'(nt_grant), 64'h2);
    bad = 0;
    repeat (1000) begin
      tick();
      if (nt_m_err !== 2'b00 || nt_grant !== 2'b10 || nt_s_cyc !== 1'b1 || nt_m_ack !== 2'b00)
        bad++;
    end
    check_eq("t6_stall_bad", 64'(bad), 64'h0);
    s_ack = 1'b1;
    #1;
    check_eq("t6_late_ack", 64'(nt_m_ack), 64'h2);
    tick();
    s_ack = 1'b0;
    drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    check_eq("t6_release", 64'(nt_grant), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
